text_console_writer: RTL



---
 rtl/text_pkg.sv | 29 ++
 rtl/text_cursor.sv | 76 +++++++
 rtl/text_console_writer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/text_pkg.sv
// Shared constants, control codes and FSM state type for the text console writer.
// No logic; latency n/a.
// Build option TEXT_WRITER_SCROLL_EN selects scroll-on-overflow versus wrap-to-top.
package text_pkg;

  localparam int          COLS   = 40;
  localparam int          ROWS   = 25;
  localparam int          ADDR_W = 10;
  localparam logic [7:0]  BLANK  = 8'h00;

  localparam logic [7:0]  CH_BS  = 8'h08;
  localparam logic [7:0]  CH_LF  = 8'h0A;
  localparam logic [7:0]  CH_FF  = 8'h0C;
  localparam logic [7:0]  CH_CR  = 8'h0D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUT,
    ST_SCROLL_RD,
    ST_SCROLL_WR,
    ST_CLEAR
  } state_t;

  // Bytes that land in text memory; everything below 0x20 and DEL is a control code.
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b != 8'h7F);
  endfunction

endpackage

// File: rtl/text_cursor.sv
// Cursor x/y counters with inc/newline/cr/back/home controls and linear address.
// Updates on the clock edge after a control is asserted; address is combinational.
// No backpressure; TEXT_WRITER_SCROLL_EN pins y at the last row on overflow, else y wraps to 0.
module text_cursor
  import text_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_inc,
  input  logic              i_newline,
  input  logic              i_cr,
  input  logic              i_back,
  input  logic              i_home,
  output logic [5:0]        o_x,
  output logic [4:0]        o_y,
  output logic              o_wrap_inc,
  output logic              o_wrap_nl,
  output logic [ADDR_W-1:0] o_addr
);

  localparam logic [5:0] LAST_X = 6'(COLS - 1);
  localparam logic [4:0] LAST_Y = 5'(ROWS - 1);

  logic [5:0] r_x;
  logic [4:0] r_y;
  logic       w_last_x;
  logic       w_last_y;
  logic [4:0] w_y_adv;

  assign w_last_x = (r_x == LAST_X);
  assign w_last_y = (r_y == LAST_Y);

`ifdef TEXT_WRITER_SCROLL_EN
  // On the last row the row index holds; the screen contents move instead.
  assign w_y_adv = w_last_y ? LAST_Y : (r_y + 5'd1);
`else
  // Without scrolling the cursor returns to the top row.
  assign w_y_adv = w_last_y ? 5'd0 : (r_y + 5'd1);
`endif

  // Overflow flags tell the writer FSM that a scroll/clear must follow the move.
  assign o_wrap_inc = w_last_x && w_last_y;
  assign o_wrap_nl  = w_last_y;

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_addr = (ADDR_W'(r_y) * ADDR_W'(COLS)) + ADDR_W'(r_x);

  // Cursor register: home has priority, then newline, cr, backspace, advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= 6'd0;
      r_y <= 5'd0;
    end else if (i_home) begin
      r_x <= 6'd0;
      r_y <= 5'd0;
    end else if (i_newline) begin
      r_x <= 6'd0;
      r_y <= w_y_adv;
    end else if (i_cr) begin
      r_x <= 6'd0;
    end else if (i_back) begin
      if (r_x != 6'd0) begin
        r_x <= r_x - 6'd1;
      end
    end else if (i_inc) begin
      if (w_last_x) begin
        r_x <= 6'd0;
        r_y <= w_y_adv;
      end else begin
        r_x <= r_x + 6'd1;
      end
    end
  end

endmodule

// File: rtl/text_console_writer.sv
// Byte stream to 40x25 text RAM writer with cursor, control codes, clear and scroll.
// Printable byte: RAM write the cycle after acceptance, 1 byte per 2 cycles; clear/scroll run to completion.
// in_ready only in IDLE; TEXT_WRITER_SCROLL_EN enables scroll on overflow (else wrap to row 0 and clear it).
module text_console_writer
  import text_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic [5:0]        cursor_x,
  output logic [4:0]        cursor_y,
  output logic              busy
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rdy;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic [ADDR_W-1:0]   r_clr_end;
  logic [ADDR_W-1:0]   w_clr_end_nxt;
  logic [7:0]          r_data;
  logic [7:0]          w_data_nxt;
  logic                r_put_adv;
  logic                w_put_adv_nxt;
  logic                r_home_pend;
  logic                w_home_pend_nxt;

  logic                w_accept;
  logic                w_ovf;
  logic                w_inc;
  logic                w_newline;
  logic                w_cr;
  logic                w_back;
  logic                w_home;
  logic                w_wrap_inc;
  logic                w_wrap_nl;
  logic [ADDR_W-1:0]   w_cur_addr;

  assign in_ready = r_rdy && (r_state == ST_IDLE);
  assign w_accept = in_valid && in_ready;
  assign busy     = (r_state == ST_SCROLL_RD) || (r_state == ST_SCROLL_WR) ||
                    (r_state == ST_CLEAR);

`ifndef TEXT_WRITER_SCROLL_EN
  // Read data is only consumed by the scroll copy.
  logic w_unused_rdata;
  assign w_unused_rdata = ^mem_rdata;
`endif

  text_cursor u_cursor (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_inc      (w_inc),
    .i_newline  (w_newline),
    .i_cr       (w_cr),
    .i_back     (w_back),
    .i_home     (w_home),
    .o_x        (cursor_x),
    .o_y        (cursor_y),
    .o_wrap_inc (w_wrap_inc),
    .o_wrap_nl  (w_wrap_nl),
    .o_addr     (w_cur_addr)
  );

  // State and datapath registers; ready is held low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rdy       <= 1'b0;
      r_cnt       <= '0;
      r_clr_end   <= '0;
      r_data      <= 8'h00;
      r_put_adv   <= 1'b0;
      r_home_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rdy       <= 1'b1;
      r_cnt       <= w_cnt_nxt;
      r_clr_end   <= w_clr_end_nxt;
      r_data      <= w_data_nxt;
      r_put_adv   <= w_put_adv_nxt;
      r_home_pend <= w_home_pend_nxt;
    end
  end

  // Next state, cursor controls and memory port drive.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_clr_end_nxt   = r_clr_end;
    w_data_nxt      = r_data;
    w_put_adv_nxt   = r_put_adv;
    w_home_pend_nxt = r_home_pend;
    w_ovf           = 1'b0;
    w_inc           = 1'b0;
    w_newline       = 1'b0;
    w_cr            = 1'b0;
    w_back          = 1'b0;
    w_home          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = 8'h00;
    mem_we          = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (in_data == CH_LF) begin
            w_newline = 1'b1;
            w_ovf     = w_wrap_nl;
          end else if (in_data == CH_CR) begin
            w_cr = 1'b1;
          end else if (in_data == CH_BS) begin
            // No reverse line wrap: backspace at column 0 is dropped.
            if (cursor_x != 6'd0) begin
              w_back        = 1'b1;
              w_data_nxt    = BLANK;
              w_put_adv_nxt = 1'b0;
              w_state_nxt   = ST_PUT;
            end
          end else if (in_data == CH_FF) begin
            w_cnt_nxt       = '0;
            w_clr_end_nxt   = ADDR_W'(ROWS * COLS - 1);
            w_home_pend_nxt = 1'b1;
            w_state_nxt     = ST_CLEAR;
          end else if (is_printable(in_data)) begin
            w_data_nxt    = in_data;
            w_put_adv_nxt = 1'b1;
            w_state_nxt   = ST_PUT;
          end
        end
      end

      ST_PUT: begin
        // Address comes from the cursor as it stands this cycle; advance happens after.
        mem_we      = 1'b1;
        mem_addr    = w_cur_addr;
        mem_wdata   = r_data;
        w_state_nxt = ST_IDLE;
        if (r_put_adv) begin
          w_inc = 1'b1;
          w_ovf = w_wrap_inc;
        end
      end

`ifdef TEXT_WRITER_SCROLL_EN
      ST_SCROLL_RD: begin
        mem_addr    = r_cnt + ADDR_W'(COLS);
        w_state_nxt = ST_SCROLL_WR;
      end

      ST_SCROLL_WR: begin
        // RAM read data from the previous cycle's address is copied one row up.
        mem_we    = 1'b1;
        mem_addr  = r_cnt;
        mem_wdata = mem_rdata;
        if (r_cnt == ADDR_W'((ROWS - 1) * COLS - 1)) begin
          w_cnt_nxt     = ADDR_W'((ROWS - 1) * COLS);
          w_clr_end_nxt = ADDR_W'(ROWS * COLS - 1);
          w_state_nxt   = ST_CLEAR;
        end else begin
          w_cnt_nxt   = r_cnt + ADDR_W'(1);
          w_state_nxt = ST_SCROLL_RD;
        end
      end
`endif

      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = r_cnt;
        mem_wdata = BLANK;
        if (r_cnt == r_clr_end) begin
          w_home          = r_home_pend;
          w_home_pend_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Cursor moved past the bottom row: scroll up, or wrap and blank the top row.
    if (w_ovf) begin
`ifdef TEXT_WRITER_SCROLL_EN
      w_cnt_nxt   = '0;
      w_state_nxt = ST_SCROLL_RD;
`else
      w_cnt_nxt     = '0;
      w_clr_end_nxt = ADDR_W'(COLS - 1);
      w_state_nxt   = ST_CLEAR;
`endif
    end
  end

endmodule
